// File: rtl/debounce_multi.sv
// N-channel key debouncer: shared ms tick, per-channel sync, debounce, edges, long press.
// Optional auto-repeat pulses are built when DEBOUNCE_REPEAT_EN is defined.
module debounce_multi #(
  parameter int NUM_CH      = 4,
  parameter int CLK_FREQ_HZ = 80000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter bit IDLE_LEVEL  = 1'b1
`ifdef DEBOUNCE_REPEAT_EN
  , parameter int REPEAT_MS = 200
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] key_in,
  output logic [NUM_CH-1:0] key_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] long_pulse,
  output logic              any_pressed,
  output logic [NUM_CH-1:0] repeat_pulse
);

  localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0] DEB = 8'(DEBOUNCE_MS);
  localparam logic [15:0] LONG = 16'(LONG_MS);
  localparam logic [NUM_CH-1:0] IDLE = {NUM_CH{IDLE_LEVEL}};

  logic [TW-1:0]     tick_q, tick_d;
  logic              tick;
  logic [NUM_CH-1:0] sync0_q, sync1_q;
  logic [NUM_CH-1:0] cand_q, cand_d;
  logic [NUM_CH-1:0] key_q, key_d;
  logic [NUM_CH-1:0] rise_q, rise_d;
  logic [NUM_CH-1:0] fall_q, fall_d;
  logic [NUM_CH-1:0] long_q, long_d;
  logic              any_q, any_d;
  logic [NUM_CH-1:0] pressed;
  logic [NUM_CH-1:0] settle;
  logic [7:0]        stab_q [NUM_CH];
  logic [7:0]        stab_d [NUM_CH];
  logic [15:0]       hold_q [NUM_CH];
  logic [15:0]       hold_d [NUM_CH];

  assign tick    = (tick_q == TICK_LAST);
  assign tick_d  = tick ? '0 : tick_q + 1'b1;
  assign pressed = key_q ^ IDLE;
  assign any_d   = |pressed;

  always_comb begin
    cand_d = cand_q;
    key_d  = key_q;
    rise_d = '0;
    fall_d = '0;
    long_d = '0;
    settle = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      stab_d[i] = stab_q[i];
      hold_d[i] = hold_q[i];
      // a moving input restarts the window even on a tick cycle
      if (sync1_q[i] != cand_q[i]) begin
        cand_d[i] = sync1_q[i];
        stab_d[i] = '0;
      end else if (tick && stab_q[i] < DEB) begin
        stab_d[i] = stab_q[i] + 8'd1;
      end
      settle[i] = (stab_q[i] == DEB) && (key_q[i] != cand_q[i]);
      if (settle[i]) begin
        key_d[i]  = cand_q[i];
        rise_d[i] = cand_q[i];
        fall_d[i] = ~cand_q[i];
      end
      if (!pressed[i]) begin
        hold_d[i] = '0;
      end else if (tick && hold_q[i] < LONG) begin
        hold_d[i] = hold_q[i] + 16'd1;
        long_d[i] = (hold_q[i] == LONG - 16'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q  <= '0;
      sync0_q <= IDLE;
      sync1_q <= IDLE;
      cand_q  <= IDLE;
      key_q   <= IDLE;
      rise_q  <= '0;
      fall_q  <= '0;
      long_q  <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        stab_q[i] <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      tick_q  <= tick_d;
      sync0_q <= key_in;
      sync1_q <= sync0_q;
      cand_q  <= cand_d;
      key_q   <= key_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      long_q  <= long_d;
      any_q   <= any_d;
      for (int i = 0; i < NUM_CH; i++) begin
        stab_q[i] <= stab_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign key_out     = key_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign long_pulse  = long_q;
  assign any_pressed = any_q;

`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [15:0] RPT = 16'(REPEAT_MS);

  logic [15:0]       rc_q [NUM_CH];
  logic [15:0]       rc_d [NUM_CH];
  logic [NUM_CH-1:0] rep_q, rep_d;

  always_comb begin
    rep_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rc_d[i] = rc_q[i];
      // releasing this cycle silences any repeat due now
      if (!pressed[i] || (settle[i] && cand_q[i] == IDLE_LEVEL)) begin
        rc_d[i] = '0;
      end else if (tick && hold_q[i] == LONG) begin
        if (rc_q[i] == RPT - 16'd1) begin
          rc_d[i]  = '0;
          rep_d[i] = 1'b1;
        end else begin
          rc_d[i] = rc_q[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_q <= '0;
      for (int i = 0; i < NUM_CH; i++) rc_q[i] <= '0;
    end else begin
      rep_q <= rep_d;
      for (int i = 0; i < NUM_CH; i++) rc_q[i] <= rc_d[i];
    end
  end

  assign repeat_pulse = rep_q;
`else
  assign repeat_pulse = '0;
`endif

endmodule
